// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// MulDiv unit: iterative HI/LO multiply/divide unit beside the E-stage ALU.
//
// Runs one radix-2 step per cycle for XLEN cycles, then one fix-up cycle that
// applies sign correction and writes the HI/LO architectural registers.
// MTHI/MTLO write HI/LO directly from IDLE without becoming busy.
//
// Ports:
//   clk     in   1     clock, all state on rising edge
//   reset   in   1     synchronous, active-high; abandons any running op
//   startE  in   1     op valid in E stage this cycle
//   opE     in   3     000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                      100 MTHI, 101 MTLO, others no-op
//   srcaE   in   XLEN  rs operand (multiplicand / dividend / move data)
//   srcbE   in   XLEN  rt operand (multiplier / divisor)
//   busy    out  1     unit is not IDLE (combinational from state)
//   done    out  1     registered 1-cycle pulse: HI/LO just updated by mul/div
//   hi      out  XLEN  HI register
//   lo      out  XLEN  LO register
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            startE,
    input  logic [2:0]      opE,
    input  logic [XLEN-1:0] srcaE,
    input  logic [XLEN-1:0] srcbE,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [2:0] opMthi = 3'b100;
    localparam logic [2:0] opMtlo = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } stateT;

    stateT           state;
    logic [CW-1:0]   count;
    logic            isDiv;
    logic            negMain;
    logic            negRem;
    logic            divZero;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] accHi;
    logic [XLEN-1:0] accLo;
    logic [XLEN-1:0] origA;

    // Start-time decode. Opcodes 000..011 are mul/div; bit 1 selects divide,
    // bit 0 selects unsigned. Operands are reduced to magnitudes up front so
    // the iteration itself is purely unsigned. Negating the most-negative
    // value yields 2^(XLEN-1), which is exactly the right unsigned magnitude.
    logic            startMulDiv;
    logic            startIsDiv;
    logic            signA;
    logic            signB;
    logic [XLEN-1:0] magA;
    logic [XLEN-1:0] magB;

    always_comb begin
        startMulDiv = (opE[2] == 1'b0);
        startIsDiv  = opE[1];
        signA       = srcaE[XLEN-1] & ~opE[0];
        signB       = srcbE[XLEN-1] & ~opE[0];
        magA        = signA ? (-srcaE) : srcaE;
        magB        = signB ? (-srcbE) : srcbE;
    end

    // One iteration step. The {accHi, accLo} pair is the working register for
    // both operations:
    //   multiply: accLo holds the multiplier and shifts right, product bits
    //             fill in from the top; accHi accumulates the partial sum.
    //   divide:   accLo holds the dividend and shifts left, quotient bits
    //             enter at the bottom; accHi is the partial remainder.
    // The remainder always stays below the divisor, so the restoring
    // subtraction fits in XLEN bits and only the compare needs the carry bit.
    logic [XLEN:0]   mulSum;
    logic [XLEN:0]   divShift;
    logic [XLEN-1:0] divDiff;
    logic            divGe;
    logic [XLEN-1:0] nextHi;
    logic [XLEN-1:0] nextLo;

    always_comb begin
        mulSum   = {1'b0, accHi} + {1'b0, (accLo[0] ? operand : '0)};
        divShift = {accHi, accLo[XLEN-1]};
        divDiff  = divShift[XLEN-1:0] - operand;
        divGe    = (divShift >= {1'b0, operand});
        if (isDiv) begin
            nextHi = divGe ? divDiff : divShift[XLEN-1:0];
            nextLo = {accLo[XLEN-2:0], divGe};
        end else begin
            nextHi = mulSum[XLEN:1];
            nextLo = {mulSum[0], accLo[XLEN-1:1]};
        end
    end

    // Sign correction applied in FIX. A zero divisor leaves the raw dividend
    // in HI and all ones in LO regardless of signedness.
    logic [2*XLEN-1:0] prodNeg;
    logic [XLEN-1:0]   fixHi;
    logic [XLEN-1:0]   fixLo;

    always_comb begin
        prodNeg = -{accHi, accLo};
        if (divZero) begin
            fixHi = origA;
            fixLo = '1;
        end else if (isDiv) begin
            fixHi = negRem  ? (-accHi) : accHi;
            fixLo = negMain ? (-accLo) : accLo;
        end else if (negMain) begin
            {fixHi, fixLo} = prodNeg;
        end else begin
            fixHi = accHi;
            fixLo = accLo;
        end
    end

    // Control FSM plus all architectural state. Requests arriving while busy
    // are dropped without side effects; the hazard unit should never send them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            isDiv   <= 1'b0;
            negMain <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            operand <= '0;
            accHi   <= '0;
            accLo   <= '0;
            origA   <= '0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (startE) begin
                        if (startMulDiv) begin
                            isDiv   <= startIsDiv;
                            negMain <= signA ^ signB;
                            negRem  <= signA;
                            divZero <= startIsDiv && (srcbE == '0);
                            origA   <= srcaE;
                            operand <= startIsDiv ? magB : magA;
                            accLo   <= startIsDiv ? magA : magB;
                            accHi   <= '0;
                            count   <= '0;
                            state   <= RUN;
                        end else if (opE == opMthi) begin
                            hi <= srcaE;
                        end else if (opE == opMtlo) begin
                            lo <= srcaE;
                        end
                    end
                end
                RUN: begin
                    accHi <= nextHi;
                    accLo <= nextLo;
                    count <= count + CW'(1);
                    if (count == CW'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= fixHi;
                    lo    <= fixLo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// Testbench for muldiv_unit (XLEN = 32).
// Directed cases from the unit's documented examples, then a randomized mix
// of mul/div/move ops compared against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int XLEN    = 32;
    localparam int LATENCY = XLEN + 2;
    localparam int TIMEOUT = 80;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b111;

    logic            clk = 1'b0;
    logic            reset;
    logic            startE;
    logic [2:0]      opE;
    logic [XLEN-1:0] srcaE;
    logic [XLEN-1:0] srcbE;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    logic [XLEN-1:0] expHi = '0;
    logic [XLEN-1:0] expLo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .startE (startE),
        .opE    (opE),
        .srcaE  (srcaE),
        .srcbE  (srcbE),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    // Runaway guard so the bench always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: architectural result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] refModel(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     q;
        longint     r;
        logic [63:0] qv;
        logic [63:0] rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULTU: return {32'h0, a} * {32'h0, b};
            OP_MULT:  return sa * sb;
            OP_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q  = sa / sb;
                r  = sa % sb;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Holds startE for exactly one cycle (cycle 0); returns in cycle 1.
    task automatic applyStimulus(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        nextCycle();
        startE = 1'b0;
        opE    = OP_NOP;
    endtask

    // Waits (bounded) for done; cyc is the current cycle number on entry.
    task automatic waitForDone(input string tag, input int startCyc,
                               input bit trace, output int cyc);
        cyc = startCyc;
        while (done !== 1'b1 && cyc < TIMEOUT) begin
            if (trace) begin
                checkOutput({tag, "-busyRun"}, 32'(busy), 32'd1);
                checkOutput({tag, "-hiHeld"}, hi, expHi);
                checkOutput({tag, "-loHeld"}, lo, expLo);
            end
            nextCycle();
            cyc++;
        end
        checkOutput({tag, "-latency"}, 32'(cyc), 32'(LATENCY));
    endtask

    // Full mul/div transaction; returns in the done cycle.
    task automatic runMulDiv(input string tag, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input bit trace);
        logic [63:0] r;
        int          cyc;
        r = refModel(op, a, b);
        applyStimulus(op, a, b);
        checkOutput({tag, "-busy1"}, 32'(busy), 32'd1);
        checkOutput({tag, "-hiHold1"}, hi, expHi);
        waitForDone(tag, 1, trace, cyc);
        expHi = r[63:32];
        expLo = r[31:0];
        checkOutput({tag, "-busyDone"}, 32'(busy), 32'd0);
        checkOutput({tag, "-hi"}, hi, expHi);
        checkOutput({tag, "-lo"}, lo, expLo);
    endtask

    task automatic runMove(input string tag, input logic [2:0] op,
                           input logic [31:0] data);
        applyStimulus(op, data, $urandom);
        if (op == OP_MTHI) expHi = data;
        else               expLo = data;
        checkOutput({tag, "-hi"}, hi, expHi);
        checkOutput({tag, "-lo"}, lo, expLo);
        checkOutput({tag, "-busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "-done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int          cyc;
        bit          sawDone;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        reset  = 1'b1;
        startE = 1'b0;
        opE    = OP_NOP;
        srcaE  = '0;
        srcbE  = '0;

        // Reset state
        nextCycle();
        nextCycle();
        reset = 1'b0;
        checkOutput("reset-busy", 32'(busy), 32'd0);
        checkOutput("reset-done", 32'(done), 32'd0);
        checkOutput("reset-hi", hi, 32'h0);
        checkOutput("reset-lo", lo, 32'h0);
        nextCycle();

        // Directed arithmetic cases, with per-cycle busy/hold tracing on MULT
        runMulDiv("multNeg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1);
        runMulDiv("multuMax", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runMulDiv("divNeg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        runMulDiv("divuZero", OP_DIVU, 32'h0000_0007, 32'h0000_0000, 1'b0);
        runMulDiv("divOvf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        runMulDiv("divZeroNeg", OP_DIV, 32'hFFFF_FF00, 32'h0000_0000, 1'b0);
        nextCycle();

        // Back-to-back moves
        runMove("mthi", OP_MTHI, 32'h0000_1234);
        runMove("mtlo", OP_MTLO, 32'h0000_5678);

        // Start while busy is ignored
        applyStimulus(OP_MULT, 32'd2, 32'd3);
        for (int i = 0; i < 4; i++) nextCycle();
        startE = 1'b1;
        opE    = OP_DIVU;
        srcaE  = 32'd9;
        srcbE  = 32'd3;
        nextCycle();
        startE = 1'b0;
        opE    = OP_NOP;
        waitForDone("ignored", 6, 1'b0, cyc);
        expHi = 32'h0;
        expLo = 32'h6;
        checkOutput("ignored-hi", hi, expHi);
        checkOutput("ignored-lo", lo, expLo);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            nextCycle();
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        checkOutput("ignored-noSecondOp", 32'(sawDone), 32'd0);

        // Reset in the middle of a divide
        applyStimulus(OP_DIV, 32'h1234_5678, 32'h0000_0013);
        for (int i = 0; i < 9; i++) nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        expHi = '0;
        expLo = '0;
        checkOutput("midReset-busy", 32'(busy), 32'd0);
        checkOutput("midReset-done", 32'(done), 32'd0);
        checkOutput("midReset-hi", hi, 32'h0);
        checkOutput("midReset-lo", lo, 32'h0);
        runMulDiv("afterReset", OP_DIVU, 32'd100, 32'd7, 1'b0);

        // Randomized mix; each op starts in the previous op's done cycle
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = randOperand();
            b  = randOperand();
            if (op >= OP_MTHI) runMove("randMove", op, a);
            else               runMulDiv("randMulDiv", op, a, b, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
